async_fifo_wr_arbiter: RTL and testbench

- Write-side scheduler that shares one dual-stage asynchronous FIFO between NREQ requesters in the wclk domain.
- Arbitrates round-robin and grants bursts of up to MAXBURST beats.
- Tags each written word with the requester ID, so the read-clock side can demultiplex.
- Honours the FIFO's combinational full flag, and counts stall cycles for performance debug.

---
 rtl/async_fifo_wr_arbiter_if.sv | 28 ++
 rtl/async_fifo_wr_arbiter.sv | 121 ++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_wr_arbiter_if.sv
// Bundle between NREQ write-domain requesters, the write arbiter and the async FIFO write port.
// The slave modport is the arbiter's view; the master modport drives requesters and the FIFO flag.
interface async_fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int WID  = 32,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_last;
    logic [NREQ*WID-1:0] req_data;
    logic [NREQ-1:0]     req_ready;
    logic                fifo_writex;
    logic [IDW+WID-1:0]  fifo_wdata;
    logic                fifo_wfull;
    logic                gnt_valid;
    logic [IDW-1:0]      gnt_id;
    logic [15:0]         stall_cnt;

    modport master (
        output req_valid, req_last, req_data, fifo_wfull,
        input  req_ready, fifo_writex, fifo_wdata, gnt_valid, gnt_id, stall_cnt
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_wfull,
        output req_ready, fifo_writex, fifo_wdata, gnt_valid, gnt_id, stall_cnt
    );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one async FIFO write port; each word is tagged with the
// requester ID so the read side can demultiplex. Stall cycles on FIFO full are counted.
module async_fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int WID      = 32,
    parameter int IDW      = 2,
    parameter int MAXBURST = 8
) (
    input  logic                    wclk,
    input  logic                    rst_nw,
    async_fifo_wr_arbiter_if.slave  bus
);
    localparam int BCW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAXBURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         state_r;
    logic [IDW-1:0] rr_ptr_r;
    logic [IDW-1:0] gnt_id_r;
    logic [BCW-1:0] beat_cnt_r;
    logic [15:0]    stall_cnt_r;

    logic           pick_found_s;
    logic [IDW-1:0] pick_id_s;
    logic [IDW-1:0] slot_s;
    logic           hit_s;
    int             idx_s;

    logic           in_burst_s;
    logic           sel_valid_s;
    logic           sel_last_s;
    logic [WID-1:0] sel_data_s;
    logic           accept_s;
    logic           stall_s;
    logic           done_s;
    logic [IDW-1:0] next_ptr_s;
    logic [NREQ-1:0] ready_s;

    // Round-robin pick: first valid requester scanning from rr_ptr upward, modulo NREQ.
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = '0;
        idx_s        = 0;
        slot_s       = '0;
        hit_s        = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s        = int'(rr_ptr_r) + k;
            idx_s        = (idx_s >= NREQ) ? (idx_s - NREQ) : idx_s;
            slot_s       = IDW'(idx_s);
            hit_s        = bus.req_valid[slot_s] && !pick_found_s;
            pick_id_s    = hit_s ? slot_s : pick_id_s;
            pick_found_s = pick_found_s || hit_s;
        end
    end

    assign in_burst_s  = (state_r == BURST);
    assign sel_valid_s = bus.req_valid[gnt_id_r];
    assign sel_last_s  = bus.req_last[gnt_id_r];
    assign sel_data_s  = bus.req_data[int'(gnt_id_r) * WID +: WID];

    // A full FIFO freezes the burst: no accept, no bubble release, only stall counting.
    assign accept_s   = in_burst_s && sel_valid_s && !bus.fifo_wfull;
    assign stall_s    = in_burst_s && sel_valid_s &&  bus.fifo_wfull;
    assign done_s     = (accept_s && (sel_last_s || (beat_cnt_r == LAST_BEAT)))
                     || (in_burst_s && !sel_valid_s && !bus.fifo_wfull);
    assign next_ptr_s = (gnt_id_r == IDW'(NREQ - 1)) ? '0 : (gnt_id_r + IDW'(1));

    // Only the granted requester sees ready, and only while the FIFO has room.
    always_comb begin
        ready_s           = '0;
        ready_s[gnt_id_r] = in_burst_s && !bus.fifo_wfull;
    end

    // Grant FSM, round-robin pointer, beat counter and saturating stall counter.
    always_ff @(posedge wclk or negedge rst_nw) begin
        if (!rst_nw) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            gnt_id_r    <= '0;
            beat_cnt_r  <= '0;
            stall_cnt_r <= 16'h0000;
        end else begin
            stall_cnt_r <= (stall_s && (stall_cnt_r != 16'hFFFF)) ? (stall_cnt_r + 16'h0001)
                                                                 : stall_cnt_r;
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        gnt_id_r   <= pick_id_s;
                        beat_cnt_r <= '0;
                        state_r    <= BURST;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                BURST: begin
                    beat_cnt_r <= accept_s ? (beat_cnt_r + BCW'(1)) : beat_cnt_r;
                    if (done_s) begin
                        rr_ptr_r <= next_ptr_s;
                        state_r  <= IDLE;
                    end else begin
                        state_r  <= BURST;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = ready_s;
    assign bus.fifo_writex = accept_s;
    assign bus.fifo_wdata  = {gnt_id_r, sel_data_s};
    assign bus.gnt_valid   = in_burst_s;
    assign bus.gnt_id      = gnt_id_r;
    assign bus.stall_cnt   = stall_cnt_r;
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Scoreboard bench: per-requester beat queues drive the arbiter, expected FIFO words are queued
// up front and a negedge monitor pops and compares every write strobe.
module tb_async_fifo_wr_arbiter;
    localparam int NREQ     = 4;
    localparam int WID      = 32;
    localparam int IDW      = 2;
    localparam int MAXBURST = 8;

    typedef struct {
        logic [WID-1:0] d;
        logic           l;
        logic           g;
    } beat_t;

    logic wclk = 1'b0;
    logic rst_nw;

    beat_t              rq [NREQ][$];
    logic [IDW+WID-1:0] exp_q[$];
    logic [NREQ-1:0]    pop_s;
    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int wr_count = 0;
    int first_wr = -1;
    int last_wr  = -1;
    int start    = 0;

    always #5 wclk = ~wclk;
    always @(posedge wclk) cyc <= cyc + 1;

    async_fifo_wr_arbiter_if #(.NREQ(NREQ), .WID(WID), .IDW(IDW)) bus ();

    async_fifo_wr_arbiter #(
        .NREQ(NREQ), .WID(WID), .IDW(IDW), .MAXBURST(MAXBURST)
    ) dut (
        .wclk  (wclk),
        .rst_nw(rst_nw),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WID-1:0] dat(input int i, input int k);
        return {8'hA0, 8'(i), 16'(k)};
    endfunction

    task automatic present();
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0 && !rq[i][0].g) begin
                bus.req_valid[i]               = 1'b1;
                bus.req_last[i]                = rq[i][0].l;
                bus.req_data[i*WID +: WID]     = rq[i][0].d;
            end else begin
                bus.req_valid[i]               = 1'b0;
                bus.req_last[i]                = 1'b0;
            end
        end
    endtask

    task automatic load(input int i, input logic [WID-1:0] d, input logic l, input logic g);
        beat_t b;
        b.d = d;
        b.l = l;
        b.g = g;
        rq[i].push_back(b);
    endtask

    task automatic expect_w(input int i, input logic [WID-1:0] d);
        exp_q.push_back({IDW'(i), d});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge wclk);
            #2;
        end
    endtask

    task automatic mark();
        wr_count = 0;
        first_wr = -1;
        last_wr  = -1;
        start    = cyc;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
        tick(3);
    endtask

    task automatic wait_writes(input string name, input int n, input int budget);
        int k = 0;
        while (wr_count < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, wr_count, n);
    endtask

    // Requester model: decide pops on the falling edge, apply them just after the rising edge.
    initial forever begin
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (pop_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        present();
    end

    // Monitor: scoreboard compare on every write strobe, plus full-flag protection checks.
    initial forever begin
        @(negedge wclk);
        for (int i = 0; i < NREQ; i++) begin
            pop_s[i] = (rq[i].size() > 0) && (rq[i][0].g || (bus.req_valid[i] && bus.req_ready[i]));
        end
        if (rst_nw) begin
            if (bus.fifo_wfull) begin
                check("write_while_full", bus.fifo_writex, 0);
                check("ready_while_full", bus.req_ready, 0);
            end
            if (bus.fifo_writex) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %0h expected no write (cycle %0d)",
                             bus.fifo_wdata, cyc);
                end else begin
                    check("wdata", bus.fifo_wdata, exp_q.pop_front());
                end
                wr_count++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] s0;
        rst_nw         = 1'b0;
        bus.req_valid  = '0;
        bus.req_last   = '0;
        bus.req_data   = '0;
        bus.fifo_wfull = 1'b0;
        pop_s          = '0;
        #1;
        check("rst_gnt_valid", bus.gnt_valid, 0);
        check("rst_writex", bus.fifo_writex, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_gnt_id", bus.gnt_id, 0);
        check("rst_stall", bus.stall_cnt, 0);
        tick(2);
        rst_nw = 1'b1;
        tick(1);

        // Round robin: everybody continuously valid, no last; requester 0 has a second burst.
        mark();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < ((i == 0) ? 16 : 8); k++) load(i, dat(i, k), 1'b0, 1'b0);
        end
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 8; k++) expect_w(i, dat(i, k));
        end
        for (int k = 8; k < 16; k++) expect_w(0, dat(0, k));
        present();
        drain("rr_drain", 200);
        check("rr_count", wr_count, 40);
        check("rr_first_latency", first_wr - start, 1);
        check("rr_span", last_wr - first_wr + 1, 44);
        check("rr_idle_after", bus.gnt_valid, 0);

        // Single requester 2, three beats with last on the third.
        mark();
        for (int k = 0; k < 3; k++) load(2, dat(2, k), (k == 2), 1'b0);
        for (int k = 0; k < 3; k++) expect_w(2, dat(2, k));
        present();
        drain("single_drain", 50);
        check("single_count", wr_count, 3);
        check("single_latency", first_wr - start, 1);
        check("single_consecutive", last_wr - first_wr, 2);
        check("single_idle", bus.gnt_valid, 0);
        check("single_gnt_hold", bus.gnt_id, 2);

        // Pointer now 3: requester 3 must win over requester 0.
        load(0, dat(0, 100), 1'b1, 1'b0);
        load(3, dat(3, 100), 1'b1, 1'b0);
        expect_w(3, dat(3, 100));
        expect_w(0, dat(0, 100));
        present();
        drain("ptr3_drain", 50);

        // Backpressure: five full cycles in the middle of a six-beat burst from requester 0.
        mark();
        for (int k = 0; k < 6; k++) load(0, dat(0, 200 + k), (k == 5), 1'b0);
        for (int k = 0; k < 6; k++) expect_w(0, dat(0, 200 + k));
        present();
        wait_writes("bp_wait", 2, 20);
        bus.fifo_wfull = 1'b1;
        s0 = bus.stall_cnt;
        tick(5);
        check("bp_stall_delta", bus.stall_cnt - s0, 5);
        check("bp_gnt_held", bus.gnt_valid, 1);
        check("bp_gnt_id", bus.gnt_id, 0);
        bus.fifo_wfull = 1'b0;
        drain("bp_drain", 50);
        check("bp_count", wr_count, 6);

        // Bubble release: requester 1 drops valid after two beats, requester 3 served in between.
        load(1, dat(1, 300), 1'b0, 1'b0);
        load(1, dat(1, 301), 1'b0, 1'b0);
        load(1, '0, 1'b0, 1'b1);
        load(1, dat(1, 302), 1'b0, 1'b0);
        load(1, dat(1, 303), 1'b1, 1'b0);
        load(3, dat(3, 300), 1'b0, 1'b0);
        load(3, dat(3, 301), 1'b1, 1'b0);
        expect_w(1, dat(1, 300));
        expect_w(1, dat(1, 301));
        expect_w(3, dat(3, 300));
        expect_w(3, dat(3, 301));
        expect_w(1, dat(1, 302));
        expect_w(1, dat(1, 303));
        present();
        drain("bubble_drain", 60);

        // Reset while beat 4 of requester 2's eight-beat burst is on the bus.
        mark();
        for (int k = 0; k < 8; k++) load(2, dat(2, 400 + k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) expect_w(2, dat(2, 400 + k));
        present();
        wait_writes("rstmid_wait", 3, 20);
        rst_nw = 1'b0;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        present();
        #1;
        check("rstmid_writex", bus.fifo_writex, 0);
        check("rstmid_ready", bus.req_ready, 0);
        check("rstmid_gnt_valid", bus.gnt_valid, 0);
        check("rstmid_gnt_id", bus.gnt_id, 0);
        check("rstmid_stall", bus.stall_cnt, 0);
        check("rstmid_scoreboard", exp_q.size(), 0);
        tick(2);
        rst_nw = 1'b1;
        tick(1);
        load(3, dat(3, 500), 1'b1, 1'b0);
        load(0, dat(0, 500), 1'b1, 1'b0);
        expect_w(0, dat(0, 500));
        expect_w(3, dat(3, 500));
        present();
        drain("rstmid_restart", 50);

        // Saturation: FIFO held full under an active grant for 70000 cycles.
        mark();
        load(1, dat(1, 600), 1'b1, 1'b0);
        expect_w(1, dat(1, 600));
        bus.fifo_wfull = 1'b1;
        present();
        tick(100);
        check("sat_early", bus.stall_cnt, 99);
        tick(65436);
        check("sat_reached", bus.stall_cnt, 16'hFFFF);
        tick(4464);
        check("sat_held", bus.stall_cnt, 16'hFFFF);
        check("sat_no_write", wr_count, 0);
        check("sat_gnt_held", bus.gnt_valid, 1);
        bus.fifo_wfull = 1'b0;
        drain("sat_drain", 20);
        check("sat_count", wr_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
